// File: rtl/pim_access_arbiter_if.sv
// ============================================================================
//  Module      : pim_access_arbiter_if
//  Description : Bundles the two requester ports (core load/store and SPI
//                debug master) and the PIM macro port of pim_access_arbiter.
//                slave  : the arbiter itself.
//                master : the surrounding environment (requesters and the
//                         PIM macro read-data return).
//                Optional LOCK inputs exist only when PIM_ARB_LOCK_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pim_access_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);

  // M0: RISC-V core load/store path
  logic          M0_REQ;
  logic          M0_WE;
  logic [AW-1:0] M0_ADDR;
  logic [DW-1:0] M0_WDATA;
  logic          M0_GNT;
  logic          M0_RVALID;
  logic [DW-1:0] M0_RDATA;

  // M1: SPI debug master
  logic          M1_REQ;
  logic          M1_WE;
  logic [AW-1:0] M1_ADDR;
  logic [DW-1:0] M1_WDATA;
  logic          M1_GNT;
  logic          M1_RVALID;
  logic [DW-1:0] M1_RDATA;

`ifdef PIM_ARB_LOCK_EN
  // Burst / atomic-sequence locks, sampled together with REQ
  logic          M0_LOCK;
  logic          M1_LOCK;
`endif

  // PIM macro side
  logic          PIM_CS;
  logic          PIM_WE;
  logic [AW-1:0] PIM_ADDR;
  logic [DW-1:0] PIM_WD;
  logic [DW-1:0] PIM_RD;

  // Status
  logic          BUSY;

  modport slave (
    input  M0_REQ, M0_WE, M0_ADDR, M0_WDATA,
    output M0_GNT, M0_RVALID, M0_RDATA,
    input  M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
    output M1_GNT, M1_RVALID, M1_RDATA,
`ifdef PIM_ARB_LOCK_EN
    input  M0_LOCK, M1_LOCK,
`endif
    output PIM_CS, PIM_WE, PIM_ADDR, PIM_WD,
    input  PIM_RD,
    output BUSY
  );

  modport master (
    output M0_REQ, M0_WE, M0_ADDR, M0_WDATA,
    input  M0_GNT, M0_RVALID, M0_RDATA,
    output M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
    input  M1_GNT, M1_RVALID, M1_RDATA,
`ifdef PIM_ARB_LOCK_EN
    output M0_LOCK, M1_LOCK,
`endif
    input  PIM_CS, PIM_WE, PIM_ADDR, PIM_WD,
    output PIM_RD,
    input  BUSY
  );

endinterface

`default_nettype wire

// File: rtl/pim_access_arbiter.sv
// ============================================================================
//  Module      : pim_access_arbiter
//  Description : Shares the single PIM macro port between the core (M0) and
//                the SPI debug master (M1). Round-robin arbitration, one
//                outstanding access at a time, fixed read latency RD_LAT.
//                All outputs are registered.
//                Optional feature macro: PIM_ARB_LOCK_EN (adds M0_LOCK /
//                M1_LOCK so the previous winner may keep the port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pim_access_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 2    // 1..15
) (
  input  logic                  CLK,
  input  logic                  RST,
  pim_access_arbiter_if.slave   bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;

  // Counter reload: WAIT lasts RD_LAT cycles, capture happens when it hits 0
  localparam logic [3:0] c_CNT_LOAD = 4'(RD_LAT - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic          r_last_winner;   // 0 = M0, 1 = M1
  logic          r_win;           // winner of the access in flight
  logic [3:0]    r_cnt;
  logic          r_busy;

  logic          r_pim_cs;
  logic          r_pim_we;
  logic [AW-1:0] r_pim_addr;
  logic [DW-1:0] r_pim_wd;

  logic          r_m0_gnt;
  logic          r_m1_gnt;
  logic          r_m0_rvalid;
  logic          r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;

  // --------------------------------------------------------------------------
  // Arbitration decision (only acted upon in IDLE)
  // --------------------------------------------------------------------------
  logic          w_any_req;
  logic          w_pick_m1;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_issue;
  logic          w_rd_done;

  // Round-robin pick, optionally overridden by the previous winner's lock
  always_comb begin
    w_any_req = bus.M0_REQ | bus.M1_REQ;
    if (bus.M0_REQ && bus.M1_REQ) begin
      w_pick_m1 = ~r_last_winner;
    end else begin
      w_pick_m1 = bus.M1_REQ;
    end
`ifdef PIM_ARB_LOCK_EN
    // A locked previous winner keeps the port; last_winner then stays put
    // because the winner equals it.
    if (!r_last_winner && bus.M0_REQ && bus.M0_LOCK) begin
      w_pick_m1 = 1'b0;
    end
    if (r_last_winner && bus.M1_REQ && bus.M1_LOCK) begin
      w_pick_m1 = 1'b1;
    end
`endif
  end

  // Mux the winner's access fields
  always_comb begin
    w_sel_we    = w_pick_m1 ? bus.M1_WE    : bus.M0_WE;
    w_sel_addr  = w_pick_m1 ? bus.M1_ADDR  : bus.M0_ADDR;
    w_sel_wdata = w_pick_m1 ? bus.M1_WDATA : bus.M0_WDATA;
    w_issue     = (r_state == c_ST_IDLE) && w_any_req;
    w_rd_done   = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
  end

  // --------------------------------------------------------------------------
  // Control FSM: state, winner history, read-latency counter and BUSY
  // --------------------------------------------------------------------------
  // Sequence IDLE -> ISSUE -> (WAIT x RD_LAT) -> IDLE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= c_ST_IDLE;
      r_last_winner <= 1'b1;
      r_win         <= 1'b0;
      r_cnt         <= 4'd0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_any_req) begin
            r_win   <= w_pick_m1;
            r_state <= c_ST_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        c_ST_ISSUE: begin
          r_last_winner <= r_win;
          if (r_pim_we) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= c_CNT_LOAD;
            r_state <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // PIM port and grant pulses, registered so they appear during ISSUE
  // --------------------------------------------------------------------------
  // Strobe/grant for one cycle; address and write data held until next issue
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pim_cs   <= 1'b0;
      r_pim_we   <= 1'b0;
      r_pim_addr <= '0;
      r_pim_wd   <= '0;
      r_m0_gnt   <= 1'b0;
      r_m1_gnt   <= 1'b0;
    end else begin
      r_pim_cs <= 1'b0;
      r_pim_we <= 1'b0;
      r_m0_gnt <= 1'b0;
      r_m1_gnt <= 1'b0;
      if (w_issue) begin
        r_pim_cs   <= 1'b1;
        r_pim_we   <= w_sel_we;
        r_pim_addr <= w_sel_addr;
        r_pim_wd   <= w_sel_wdata;
        r_m0_gnt   <= ~w_pick_m1;
        r_m1_gnt   <= w_pick_m1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read return: capture PIM_RD into the winner's RDATA on the last WAIT cycle
  // --------------------------------------------------------------------------
  // RVALID pulses for one cycle; the other requester's RDATA is untouched
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      if (w_rd_done) begin
        if (r_win) begin
          r_m1_rdata  <= bus.PIM_RD;
          r_m1_rvalid <= 1'b1;
        end else begin
          r_m0_rdata  <= bus.PIM_RD;
          r_m0_rvalid <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.PIM_CS    = r_pim_cs;
  assign bus.PIM_WE    = r_pim_we;
  assign bus.PIM_ADDR  = r_pim_addr;
  assign bus.PIM_WD    = r_pim_wd;
  assign bus.M0_GNT    = r_m0_gnt;
  assign bus.M1_GNT    = r_m1_gnt;
  assign bus.M0_RVALID = r_m0_rvalid;
  assign bus.M1_RVALID = r_m1_rvalid;
  assign bus.M0_RDATA  = r_m0_rdata;
  assign bus.M1_RDATA  = r_m1_rdata;
  assign bus.BUSY      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pim_access_arbiter.sv
// ============================================================================
//  Module      : tb_pim_access_arbiter
//  Description : Self-checking bench for pim_access_arbiter. Expected grants
//                are queued as stimulus is issued and compared when the DUT
//                grants; reads move to a return queue and are compared on
//                RVALID (owner, data, latency). Honours PIM_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pim_access_arbiter;

  localparam int AW     = 12;
  localparam int DW     = 32;
  parameter  int RD_LAT = 2;

  typedef struct {
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } acc_t;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
    int            cyc;
  } rd_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  acc_t gnt_q[$];
  rd_t  rd_q[$];
  logic [DW-1:0] exp_rdata [2];

  pim_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  pim_access_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // PIM macro model: read data valid exactly RD_LAT cycles after the CS cycle
  // --------------------------------------------------------------------------
  function automatic logic [DW-1:0] pim_data(input logic [AW-1:0] a);
    if (a == 12'h020) return 32'h1234_5678;
    return {8'hA5, 12'h000, a};
  endfunction

  function automatic logic [DW-1:0] wd_of(input int who, input logic [AW-1:0] a);
    return {(who == 1) ? 8'hB1 : 8'hB0, 12'h000, a};
  endfunction

  int            age;
  logic [AW-1:0] rd_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= 0;
      rd_addr <= '0;
    end else if (bus.PIM_CS && !bus.PIM_WE) begin
      age <= 1;
      rd_addr <= bus.PIM_ADDR;
    end else if (age != 0 && age < 20) begin
      age <= age + 1;
    end
  end

  assign bus.PIM_RD = (age == RD_LAT) ? pim_data(rd_addr) : 32'hBAD0_BAD0;

  // --------------------------------------------------------------------------
  // Scoreboard monitor, sampled on the falling edge
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    acc_t e;
    rd_t  r;
    if (!rst) begin
      cyc++;
      if (bus.M0_GNT || bus.M1_GNT) begin
        check("gnt_exclusive", {63'd0, bus.M0_GNT & bus.M1_GNT}, 64'd0);
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 64'd1, 64'd0);
        end else begin
          e = gnt_q.pop_front();
          check("gnt_who",  {63'd0, bus.M1_GNT}, 64'(e.who));
          check("pim_cs",   {63'd0, bus.PIM_CS}, 64'd1);
          check("pim_we",   {63'd0, bus.PIM_WE}, {63'd0, e.we});
          check("pim_addr", 64'(bus.PIM_ADDR), 64'(e.addr));
          check("pim_wd",   64'(bus.PIM_WD), 64'(e.wd));
          if (!e.we) rd_q.push_back('{who: e.who, data: pim_data(e.addr), cyc: cyc});
        end
      end
      if (bus.M0_RVALID || bus.M1_RVALID) begin
        check("rvalid_exclusive", {63'd0, bus.M0_RVALID & bus.M1_RVALID}, 64'd0);
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 64'd1, 64'd0);
        end else begin
          r = rd_q.pop_front();
          exp_rdata[r.who] = r.data;
          check("rvalid_who", {63'd0, bus.M1_RVALID}, 64'(r.who));
          check("rd_latency", 64'(cyc - r.cyc), 64'(RD_LAT + 1));
          check("m0_rdata", 64'(bus.M0_RDATA), 64'(exp_rdata[0]));
          check("m1_rdata", 64'(bus.M1_RDATA), 64'(exp_rdata[1]));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Requester drivers
  // --------------------------------------------------------------------------
  task automatic set_req(input int who, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    if (who == 0) begin
      bus.M0_REQ = req; bus.M0_WE = we; bus.M0_ADDR = a; bus.M0_WDATA = d;
`ifdef PIM_ARB_LOCK_EN
      bus.M0_LOCK = lk;
`endif
    end else begin
      bus.M1_REQ = req; bus.M1_WE = we; bus.M1_ADDR = a; bus.M1_WDATA = d;
`ifdef PIM_ARB_LOCK_EN
      bus.M1_LOCK = lk;
`endif
    end
  endtask

  function automatic logic gnt_of(input int who);
    return (who == 0) ? bus.M0_GNT : bus.M1_GNT;
  endfunction

  // Raise REQ and hold it until GNT; lat = cycles from request to GNT
  task automatic req_one(input int who, input logic we, input logic [AW-1:0] a,
                         input logic lk, output int lat);
    set_req(who, 1'b1, we, a, wd_of(who, a), lk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!gnt_of(who) && lat < 60);
    if (!gnt_of(who)) check($sformatf("gnt_timeout_m%0d", who), 64'd0, 64'd1);
  endtask

  // Back-to-back requests with REQ kept high between them
  task automatic run_seq(input int who, input int n, input logic we,
                         input logic [AW-1:0] base, input logic lk);
    int lat;
    for (int k = 0; k < n; k++) req_one(who, we, base + AW'(k), lk, lat);
    set_req(who, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((gnt_q.size() != 0 || rd_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("queues_drained", 64'(gnt_q.size() + rd_q.size()), 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy",     {63'd0, bus.BUSY},   64'd0);
    check("rst_pim_cs",   {63'd0, bus.PIM_CS}, 64'd0);
    check("rst_pim_addr", 64'(bus.PIM_ADDR),   64'd0);
    check("rst_m0_rdata", 64'(bus.M0_RDATA),   64'd0);

    // M0 write: issued in the second cycle, BUSY clears the cycle after
    gnt_q.push_back('{who: 0, we: 1'b1, addr: 12'h010, wd: wd_of(0, 12'h010)});
    set_req(0, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0);
    gnt_q[0].wd = 32'hDEAD_BEEF;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.M0_GNT && lat < 60);
    check("m0_wr_gnt_lat", 64'(lat), 64'd1);
    check("m0_wr_busy",    {63'd0, bus.BUSY}, 64'd1);
    set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    check("m0_wr_busy_clr", {63'd0, bus.BUSY}, 64'd0);
    wait_drain();

    // M1 single read of 0x020
    gnt_q.push_back('{who: 1, we: 1'b0, addr: 12'h020, wd: wd_of(1, 12'h020)});
    req_one(1, 1'b0, 12'h020, 1'b0, lat);
    set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
    wait_drain();
    check("m1_rd_data", 64'(bus.M1_RDATA), 64'h1234_5678);

    // Both requesters reading continuously: strict alternation from M0
    for (int k = 0; k < 3; k++) begin
      gnt_q.push_back('{who: 0, we: 1'b0, addr: 12'h100 + 12'(k), wd: wd_of(0, 12'h100 + 12'(k))});
      gnt_q.push_back('{who: 1, we: 1'b0, addr: 12'h200 + 12'(k), wd: wd_of(1, 12'h200 + 12'(k))});
    end
    fork
      run_seq(0, 3, 1'b0, 12'h100, 1'b0);
      run_seq(1, 3, 1'b0, 12'h200, 1'b0);
    join
    wait_drain();

    // Reset in the WAIT phase of an M0 read drops the read
    gnt_q.push_back('{who: 0, we: 1'b0, addr: 12'h030, wd: wd_of(0, 12'h030)});
    req_one(0, 1'b0, 12'h030, 1'b0, lat);
    set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    check("wait_busy", {63'd0, bus.BUSY}, 64'd1);
    rst = 1'b1;
    rd_q.delete();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    #1;
    check("arst_busy",     {63'd0, bus.BUSY},   64'd0);
    check("arst_pim_cs",   {63'd0, bus.PIM_CS}, 64'd0);
    check("arst_pim_addr", 64'(bus.PIM_ADDR),   64'd0);
    check("arst_m0_rdata", 64'(bus.M0_RDATA),   64'd0);
    check("arst_m1_rdata", 64'(bus.M1_RDATA),   64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (RD_LAT + 3) begin
      @(posedge clk); #1;
      check("no_rvalid_after_rst", {63'd0, bus.M0_RVALID | bus.PIM_CS}, 64'd0);
    end
    gnt_q.push_back('{who: 1, we: 1'b1, addr: 12'h040, wd: wd_of(1, 12'h040)});
    req_one(1, 1'b1, 12'h040, 1'b0, lat);
    set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
    check("m1_wr_gnt_lat", 64'(lat), 64'd1);
    wait_drain();

`ifdef PIM_ARB_LOCK_EN
    // M1 (previous winner) locks three writes while M0 keeps requesting
    for (int k = 0; k < 3; k++)
      gnt_q.push_back('{who: 1, we: 1'b1, addr: 12'h300 + 12'(k), wd: wd_of(1, 12'h300 + 12'(k))});
    gnt_q.push_back('{who: 0, we: 1'b1, addr: 12'h050, wd: wd_of(0, 12'h050)});
    fork
      run_seq(1, 3, 1'b1, 12'h300, 1'b1);
      run_seq(0, 1, 1'b1, 12'h050, 1'b0);
    join
    wait_drain();
`endif

    // Read return timing for this RD_LAT build, M0 side
    gnt_q.push_back('{who: 0, we: 1'b0, addr: 12'h060, wd: wd_of(0, 12'h060)});
    req_one(0, 1'b0, 12'h060, 1'b0, lat);
    set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
    wait_drain();
    check("m0_rd_data", 64'(bus.M0_RDATA), 64'(pim_data(12'h060)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
